seq_bcd_display_engine: RTL and testbench

Sequential successor to the combinational BCD sequence display path. It accepts a signed two's-complement value through a valid/ready handshake and converts it to BCD with a multi-cycle double-dabble (one shift per cycle). The result is committed atomically into a display register, so the screen never shows a half-converted value. Each glyph slot is rendered as an 8x8 font pixel, magnified by 2^SCALE_SHIFT, with a registered RGB output for the VGA pixel pipeline.

---
 rtl/seq_disp_pkg.sv | 28 ++
 rtl/digit_glyph_rom_8.sv | 33 +++
 rtl/seq_bcd_display_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_seq_bcd_display_engine.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_disp_pkg.sv
// Shared glyph codes, font geometry and FSM encoding for the sequential BCD display engine.
// Optional leading-zero blanking in the top level is enabled with SEQ_DISP_LZB_EN.
package seq_disp_pkg;

  localparam logic [3:0] GLYPH_MINUS = 4'hA;
  localparam logic [3:0] GLYPH_BLANK = 4'hB;
  localparam int         FONT_ROWS   = 8;
  localparam int         BCD_WIDTH   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ABS     = 2'd1,
    ST_CONVERT = 2'd2,
    ST_COMMIT  = 2'd3
  } seq_state_e;

  // Double-dabble correction applied to a nibble before each shift.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/digit_glyph_rom_8.sv
// 8x8 glyph bitmaps for decimal digits and the minus sign; row 7 is the top scan line.
// Blank and any unused code render as an empty row.
module digit_glyph_rom_8
  import seq_disp_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic [2:0] row_i,
  output logic [7:0] bits_o
);

  logic [63:0] glyph_s;

  // Glyph lookup (top scan line in the most significant byte) and row select.
  always_comb begin
    glyph_s = 64'h0000_0000_0000_0000;
    case (code_i)
      4'd0:        glyph_s = 64'h3C66_6E76_6666_3C00;
      4'd1:        glyph_s = 64'h1838_1818_1818_7E00;
      4'd2:        glyph_s = 64'h3C66_060C_3060_7E00;
      4'd3:        glyph_s = 64'h3C66_061C_0666_3C00;
      4'd4:        glyph_s = 64'h0C1C_3C6C_7E0C_0C00;
      4'd5:        glyph_s = 64'h7F60_7C06_0666_3C00;
      4'd6:        glyph_s = 64'h3C60_7C66_6666_3C00;
      4'd7:        glyph_s = 64'h7E06_0C18_3030_3000;
      4'd8:        glyph_s = 64'h3C66_663C_6666_3C00;
      4'd9:        glyph_s = 64'h3C66_663E_060C_3800;
      GLYPH_MINUS: glyph_s = 64'h0000_007E_7E00_0000;
      default:     glyph_s = 64'h0000_0000_0000_0000;
    endcase
    bits_o = glyph_s[{row_i, 3'b000} +: 8];
  end

endmodule

// File: rtl/seq_bcd_display_engine.sv
// Handshaked signed-to-BCD converter (one double-dabble shift per cycle) with an atomically
// committed display register and a registered glyph pixel path. Macro: SEQ_DISP_LZB_EN.
module seq_bcd_display_engine
  import seq_disp_pkg::*;
#(
  parameter int                     SCREEN_WIDTH = 10,
  parameter int                     SEQ_LEN      = 20,
  parameter int                     DIGITS       = 6,
  parameter int                     PIXEL_WIDTH  = 12,
  parameter int                     FONT_WIDTH   = 8,
  parameter int                     SCALE_SHIFT  = 0,
  parameter logic [PIXEL_WIDTH-1:0] FG_COLOR     = 12'hFFF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEQ_LEN-1:0]      in_value,
  output logic                    done,
  output logic                    overflow,
  input  logic                    disp_on,
  input  logic [SCREEN_WIDTH-1:0] x_rom,
  input  logic [SCREEN_WIDTH-1:0] y_rom,
  input  logic [PIXEL_WIDTH-1:0]  background_rgb,
  output logic [PIXEL_WIDTH-1:0]  rgb
);

  localparam int BW      = DIGITS * BCD_WIDTH;
  localparam int CW      = $clog2(SEQ_LEN + 1);
  localparam int FW_LOG2 = $clog2(FONT_WIDTH);

  seq_state_e              state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic [SEQ_LEN-1:0]      value_q, value_d;
  logic [SEQ_LEN-1:0]      bin_q, bin_d;
  logic [BW-1:0]           bcd_q, bcd_d;
  logic                    ovf_q, ovf_d;
  logic                    neg_q, neg_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           disp_digits_q, disp_digits_d;
  logic                    disp_neg_q, disp_neg_d;
  logic                    done_q, done_d;
  logic                    overflow_q, overflow_d;
  logic [PIXEL_WIDTH-1:0]  rgb_q, rgb_d;

  logic [BW-1:0]           bcd_adj_s;
  logic [BW-1:0]           commit_digits_s;

`ifdef SEQ_DISP_LZB_EN
  logic [DIGITS-1:0]       disp_blank_q, disp_blank_d;
  logic [DIGITS-1:0]       blank_s;
  logic                    lead_s;
`endif

  assign commit_digits_s = ovf_q ? {DIGITS{4'h9}} : bcd_q;

  // Per-nibble add-3 correction ahead of the next shift.
  always_comb begin
    bcd_adj_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj_s[i*BCD_WIDTH +: BCD_WIDTH] = bcd_adjust(bcd_q[i*BCD_WIDTH +: BCD_WIDTH]);
    end
  end

`ifdef SEQ_DISP_LZB_EN
  // A digit blanks only when it and every more significant digit are zero; digit 0 always shows.
  always_comb begin
    blank_s = '0;
    lead_s  = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead_s     = lead_s && (commit_digits_s[i*BCD_WIDTH +: BCD_WIDTH] == 4'd0);
      blank_s[i] = lead_s;
    end
  end
`endif

  // Conversion FSM next-state and datapath.
  always_comb begin
    state_d       = state_q;
    value_d       = value_q;
    bin_d         = bin_q;
    bcd_d         = bcd_q;
    ovf_d         = ovf_q;
    neg_d         = neg_q;
    cnt_d         = cnt_q;
    disp_digits_d = disp_digits_q;
    disp_neg_d    = disp_neg_q;
    done_d        = 1'b0;
    overflow_d    = overflow_q;
`ifdef SEQ_DISP_LZB_EN
    disp_blank_d  = disp_blank_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          value_d = in_value;
          state_d = ST_ABS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ABS: begin
        neg_d   = value_q[SEQ_LEN-1];
        // The most negative input negates to itself, which as unsigned is its true magnitude.
        if (value_q[SEQ_LEN-1]) begin
          bin_d = ~value_q + SEQ_LEN'(1);
        end else begin
          bin_d = value_q;
        end
        bcd_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        ovf_d = ovf_q | bcd_adj_s[BW-1];
        bcd_d = {bcd_adj_s[BW-2:0], bin_q[SEQ_LEN-1]};
        bin_d = {bin_q[SEQ_LEN-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(SEQ_LEN - 1)) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_CONVERT;
        end
      end
      ST_COMMIT: begin
        disp_digits_d = commit_digits_s;
        disp_neg_d    = neg_q;
        overflow_d    = ovf_q;
        done_d        = 1'b1;
`ifdef SEQ_DISP_LZB_EN
        disp_blank_d  = blank_s;
`endif
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // Conversion state, working registers and the committed display register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      in_ready_q    <= 1'b1;
      value_q       <= '0;
      bin_q         <= '0;
      bcd_q         <= '0;
      ovf_q         <= 1'b0;
      neg_q         <= 1'b0;
      cnt_q         <= '0;
      disp_digits_q <= '0;
      disp_neg_q    <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
`ifdef SEQ_DISP_LZB_EN
      disp_blank_q  <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      value_q       <= value_d;
      bin_q         <= bin_d;
      bcd_q         <= bcd_d;
      ovf_q         <= ovf_d;
      neg_q         <= neg_d;
      cnt_q         <= cnt_d;
      disp_digits_q <= disp_digits_d;
      disp_neg_q    <= disp_neg_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
`ifdef SEQ_DISP_LZB_EN
      disp_blank_q  <= disp_blank_d;
`endif
    end
  end

  logic [SCREEN_WIDTH-1:0] gx_s, gy_s, slot_s;
  logic [FW_LOG2-1:0]      col_s;
  logic [2:0]              row_s;
  logic [3:0]              code_s;
  logic [7:0]              bitmap_s;
  logic                    lit_s;

  assign gx_s   = x_rom >> SCALE_SHIFT;
  assign gy_s   = y_rom >> SCALE_SHIFT;
  assign slot_s = gx_s >> FW_LOG2;
  assign col_s  = gx_s[FW_LOG2-1:0];
  assign row_s  = 3'd7 - gy_s[2:0];

  // Slot 0 carries the sign; slots 1..DIGITS show digits most significant first.
  always_comb begin
    code_s = GLYPH_BLANK;
    if (slot_s == '0) begin
      code_s = disp_neg_q ? GLYPH_MINUS : GLYPH_BLANK;
    end else begin
      for (int k = 1; k <= DIGITS; k++) begin
`ifdef SEQ_DISP_LZB_EN
        code_s = (slot_s == SCREEN_WIDTH'(k))
               ? (disp_blank_q[DIGITS-k] ? GLYPH_BLANK
                                          : disp_digits_q[(DIGITS-k)*BCD_WIDTH +: BCD_WIDTH])
               : code_s;
`else
        code_s = (slot_s == SCREEN_WIDTH'(k))
               ? disp_digits_q[(DIGITS-k)*BCD_WIDTH +: BCD_WIDTH]
               : code_s;
`endif
      end
    end
  end

  digit_glyph_rom_8 u_glyph_rom (
    .code_i (code_s),
    .row_i  (row_s),
    .bits_o (bitmap_s)
  );

  // Foreground only inside the region, within the glyph slots and within the font height.
  always_comb begin
    lit_s = disp_on
         && (slot_s <= SCREEN_WIDTH'(DIGITS))
         && (gy_s < SCREEN_WIDTH'(FONT_ROWS))
         && bitmap_s[FW_LOG2'(FONT_WIDTH - 1) - col_s];
    if (lit_s) begin
      rgb_d = FG_COLOR;
    end else begin
      rgb_d = background_rgb;
    end
  end

  // Registered pixel colour for the VGA pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign in_ready = in_ready_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign rgb      = rgb_q;

endmodule

// File: tb/tb_seq_bcd_display_engine.sv
// Randomised and directed bench for seq_bcd_display_engine (6-digit and 4-digit instances)
// checked against an arithmetic model of the committed value and its rendered glyphs.
module tb_seq_bcd_display_engine;

  localparam int SW = 10;
  localparam int SL = 20;
  localparam int PW = 12;
  localparam logic [PW-1:0] FG = 12'hFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, disp_on;
  logic [SL-1:0] in_value;
  logic [SW-1:0] x_rom, y_rom;
  logic [PW-1:0] bg;
  logic          in_ready, done, overflow;
  logic [PW-1:0] rgb;
  logic          in_ready4, done4, overflow4;
  logic [PW-1:0] rgb4;

  seq_bcd_display_engine #(.SCREEN_WIDTH(SW), .SEQ_LEN(SL), .DIGITS(6), .PIXEL_WIDTH(PW),
                           .FONT_WIDTH(8), .SCALE_SHIFT(0), .FG_COLOR(FG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .done(done), .overflow(overflow), .disp_on(disp_on), .x_rom(x_rom), .y_rom(y_rom),
    .background_rgb(bg), .rgb(rgb));

  seq_bcd_display_engine #(.SCREEN_WIDTH(SW), .SEQ_LEN(SL), .DIGITS(4), .PIXEL_WIDTH(PW),
                           .FONT_WIDTH(8), .SCALE_SHIFT(0), .FG_COLOR(FG)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_value(in_value),
    .done(done4), .overflow(overflow4), .disp_on(disp_on), .x_rom(x_rom), .y_rom(y_rom),
    .background_rgb(bg), .rgb(rgb4));

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int cur_val = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int sext(input logic [SL-1:0] v);
    int r;
    r = $signed(v);
    return r;
  endfunction

  function automatic logic [63:0] glyph(input int code);
    case (code)
      0: return 64'h3C666E7666663C00;
      1: return 64'h1838181818187E00;
      2: return 64'h3C66060C30607E00;
      3: return 64'h3C66061C06663C00;
      4: return 64'h0C1C3C6C7E0C0C00;
      5: return 64'h7F607C0606663C00;
      6: return 64'h3C607C6666663C00;
      7: return 64'h7E060C1830303000;
      8: return 64'h3C66663C66663C00;
      9: return 64'h3C66663E060C3800;
      10: return 64'h0000007E7E000000;
      default: return 64'h0;
    endcase
  endfunction

  // Expected colour: value shown as sign + 'digits' decimal digits, 8x8 glyphs, top line y=0.
  function automatic logic [PW-1:0] exp_rgb(input int digits, input int val, input int x,
                                            input int y, input bit don, input logic [PW-1:0] bgc);
    int slot, c, code, mag, d;
    bit ovf;
    logic [7:0] line;
    slot = x / 8;
    c = x % 8;
    if (!don || slot > digits || y >= 8) return bgc;
    mag = (val < 0) ? -val : val;
    ovf = mag > pow10(digits) - 1;
    if (slot == 0) begin
      code = (val < 0) ? 10 : 11;
    end else begin
      d = digits - slot;
      code = ovf ? 9 : (mag / pow10(d)) % 10;
`ifdef SEQ_DISP_LZB_EN
      if (!ovf && d > 0 && mag < pow10(d)) code = 11;
`endif
    end
    line = 8'(glyph(code) >> ((7 - y) * 8));
    return line[7 - c] ? FG : bgc;
  endfunction

  task automatic pixel(input string tag, input int x, input int y, input bit don);
    logic [PW-1:0] b;
    @(negedge clk);
    b = PW'($urandom);
    x_rom = SW'(x);
    y_rom = SW'(y);
    disp_on = don;
    bg = b;
    @(negedge clk);
    check({tag, "_rgb6"}, 32'(rgb), 32'(exp_rgb(6, cur_val, x, y, don, b)));
    check({tag, "_rgb4"}, 32'(rgb4), 32'(exp_rgb(4, cur_val, x, y, don, b)));
  endtask

  task automatic pixel_sweep(input string tag);
    pixel({tag, "_p48"}, 48, 0, 1'b1);
    pixel({tag, "_p49"}, 49, 0, 1'b1);
    pixel({tag, "_sign"}, 1, 4, 1'b1);
    pixel({tag, "_p26"}, 26, 3, 1'b1);
    pixel({tag, "_y8"}, 42, 8, 1'b1);
    for (int i = 0; i < 6; i++) begin
      pixel({tag, "_rnd"}, int'($urandom_range(0, 70)), int'($urandom_range(0, 9)),
            ($urandom_range(0, 3) != 0));
    end
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic transact(input string tag, input logic [SL-1:0] v);
    int cyc, low;
    bit found;
    int sv;
    wait_ready(tag);
    in_valid = 1'b1;
    in_value = v;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    low = 0;
    found = 1'b0;
    while (!found && cyc < 60) begin
      @(negedge clk);
      if (done) found = 1'b1;
      else begin
        if (!in_ready) low++;
        cyc++;
      end
    end
    check({tag, "_latency"}, 32'(cyc), 32'd22);
    check({tag, "_ready_low"}, 32'(low), 32'd22);
    check({tag, "_done4"}, 32'(done4), 32'd1);
    sv = sext(v);
    cur_val = sv;
    check({tag, "_ovf6"}, 32'(overflow), 32'(((sv < 0) ? -sv : sv) > 999999));
    check({tag, "_ovf4"}, 32'(overflow4), 32'(((sv < 0) ? -sv : sv) > 9999));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    pixel_sweep(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, d1, low;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    disp_on = 1'b0;
    x_rom = '0;
    y_rom = '0;
    bg = 12'h000;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_rgb", 32'(rgb), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    pixel_sweep("rst_disp");

    transact("v12345", 20'd12345);
    transact("vneg1", 20'hFFFFF);
    transact("vmin", 20'h80000);
    transact("vmax", 20'h7FFFF);
    transact("vzero", 20'd0);
    transact("v9999", 20'd9999);
    transact("v10000", 20'd10000);
    for (int i = 0; i < 4; i++) transact("vrnd", SL'($urandom));

    // Source holds in_valid across two values.
    wait_ready("b2b");
    in_valid = 1'b1;
    in_value = 20'd5;
    @(posedge clk);
    #1 in_value = 20'd7;
    d0 = -1;
    d1 = -1;
    low = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (done && d0 < 0) d0 = cyc;
      else if (done && d1 < 0) d1 = cyc;
      if (!in_ready && d0 < 0) low++;
      if (cyc == 23) in_valid = 1'b0;
    end
    check("b2b_first_done", 32'(d0), 32'd22);
    check("b2b_gap", 32'(d1 - d0), 32'd23);
    check("b2b_ready_low", 32'(low), 32'd22);
    cur_val = 7;
    pixel_sweep("b2b");

    // Reset in the middle of a conversion.
    wait_ready("abort");
    in_valid = 1'b1;
    in_value = 20'd12345;
    @(posedge clk);
    #1 in_valid = 1'b0;
    disp_on = 1'b0;
    bg = 12'h5A5;
    repeat (11) @(negedge clk);
    check("abort_pre_rgb", 32'(rgb), 32'h5A5);
    #1 rst_n = 1'b0;
    #1;
    check("abort_rgb6", 32'(rgb), 32'd0);
    check("abort_rgb4", 32'(rgb4), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cur_val = 0;
    check("abort_ovf", 32'(overflow), 32'd0);
    pixel("abort_bg", 10, 2, 1'b0);
    pixel_sweep("abort_disp");
    repeat (30) begin
      @(negedge clk);
      if (done) check("abort_no_done", 32'(done), 32'd0);
    end
    transact("post_abort", 20'd321);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
